// File: rtl/led_flash_arbiter_if.sv
// Requester-side bundle of the LED flash arbiter: request/abort inputs and
// the shared LED bank, grant and status outputs.
interface led_flash_arbiter_if;
  logic [3:0] req;
  logic       clear;
  logic [3:0] led_on;
  logic [1:0] grant_id;
  logic       busy;
  logic [3:0] pending;
  logic [3:0] ack;
  logic [1:0] fsm_state;

  modport master (
    output req, clear,
    input  led_on, grant_id, busy, pending, ack, fsm_state
  );

  modport slave (
    input  req, clear,
    output led_on, grant_id, busy, pending, ack, fsm_state
  );
endinterface

// File: rtl/led_flash_arbiter.sv
// Round-robin arbiter sharing one LED bank among four requesters: each grant
// lights the bank for FLASH_CYCLES, then holds it dark for GAP_CYCLES.
module led_flash_arbiter #(
  parameter int unsigned SYS_FREQ     = 100000000,
  parameter int unsigned FLASH_CYCLES = 50000000,
  parameter int unsigned GAP_CYCLES   = 10000000
) (
  input logic               clk,
  input logic               reset,
  led_flash_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLASH = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [31:0] FLASH_LAST = 32'(FLASH_CYCLES - 1);
  localparam bit          HAS_GAP    = (GAP_CYCLES != 0);
  localparam logic [31:0] GAP_LAST   = HAS_GAP ? 32'(GAP_CYCLES - 1) : 32'd0;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] count;
  logic [3:0]  pending;
  logic [1:0]  grant_id;
  logic [1:0]  last_grant;
  logic [3:0]  ack;
  logic [1:0]  sel;
  logic [1:0]  cand;
  logic        grant_now;
  logic [3:0]  grant_mask;
  logic [3:0]  led_on;
  logic        busy;

  // SYS_FREQ is documentation only; fold it into a deliberately unused sink.
  logic unused_sys_freq;
  assign unused_sys_freq = ^SYS_FREQ;

  // Round-robin pick: scan offsets 4..1 from last_grant so the nearest
  // pending requester after last_grant is the one left in sel.
  always_comb begin
    sel  = last_grant;
    cand = '0;
    for (int k = 4; k >= 1; k--) begin
      cand = last_grant + 2'(k);
      if (pending[cand]) sel = cand;
    end
  end

  assign grant_now  = (state == S_IDLE) && (|pending);
  assign grant_mask = grant_now ? (4'b0001 << sel) : 4'b0000;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.clear) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (|pending) state_nxt = S_FLASH;
        S_FLASH: if (count == FLASH_LAST) state_nxt = HAS_GAP ? S_GAP : S_IDLE;
        S_GAP:   if (count == GAP_LAST) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    led_on = (state == S_FLASH) ? (4'b0001 << grant_id) : 4'b0000;
    busy   = (state != S_IDLE);
  end

  // A new req on the bit being granted in the same edge keeps it pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count      <= '0;
      pending    <= '0;
      grant_id   <= 2'd0;
      last_grant <= 2'd3;
      ack        <= '0;
    end else if (bus.clear) begin
      count   <= '0;
      pending <= '0;
      ack     <= '0;
    end else begin
      ack     <= '0;
      pending <= (pending & ~grant_mask) | bus.req;
      case (state)
        S_IDLE: begin
          if (grant_now) begin
            grant_id   <= sel;
            last_grant <= sel;
            count      <= '0;
          end
        end
        S_FLASH: begin
          if (count == FLASH_LAST) begin
            count <= '0;
            ack   <= 4'b0001 << grant_id;
          end else begin
            count <= count + 32'd1;
          end
        end
        S_GAP: begin
          if (count == GAP_LAST) count <= '0;
          else                   count <= count + 32'd1;
        end
        default: count <= '0;
      endcase
    end
  end

  assign bus.led_on    = led_on;
  assign bus.busy      = busy;
  assign bus.grant_id  = grant_id;
  assign bus.pending   = pending;
  assign bus.ack       = ack;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_led_flash_arbiter.sv
// Bench for led_flash_arbiter: two instances (gap of 3 and gap of 0) driven
// in lockstep and compared against a phase/countdown reference model.
module tb_led_flash_arbiter;

  localparam int FLASH = 8;
  localparam int GAP_A = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  led_flash_arbiter_if bus_a();
  led_flash_arbiter_if bus_b();

  led_flash_arbiter #(
    .SYS_FREQ(100000000), .FLASH_CYCLES(FLASH), .GAP_CYCLES(GAP_A)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );

  led_flash_arbiter #(
    .SYS_FREQ(100000000), .FLASH_CYCLES(FLASH), .GAP_CYCLES(0)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 lit, 2 dark; cycles left counts down.
  int         m_phase[2];
  int         m_left[2];
  int         m_last[2];
  int         m_served[2];
  logic [3:0] m_pend[2];
  logic [3:0] m_ack[2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_phase[m]  = 0;
      m_left[m]   = 0;
      m_last[m]   = 3;
      m_served[m] = 0;
      m_pend[m]   = '0;
      m_ack[m]    = '0;
    end
  endtask

  task automatic model_step(input int m, input logic [3:0] r, input logic c);
    int  gap;
    bit  found;
    int  idx;
    gap      = (m == 0) ? GAP_A : 0;
    m_ack[m] = '0;
    if (c) begin
      m_pend[m]  = '0;
      m_phase[m] = 0;
      m_left[m]  = 0;
    end else begin
      case (m_phase[m])
        0: begin
          if (m_pend[m] != 4'b0000) begin
            found = 1'b0;
            for (int k = 1; k <= 4; k++) begin
              idx = (m_last[m] + k) % 4;
              if (!found && m_pend[m][idx]) begin
                found       = 1'b1;
                m_served[m] = idx;
              end
            end
            m_last[m]              = m_served[m];
            m_pend[m][m_served[m]] = 1'b0;
            m_phase[m]             = 1;
            m_left[m]              = FLASH;
          end
        end
        1: begin
          m_left[m]--;
          if (m_left[m] == 0) begin
            m_ack[m] = 4'(1 << m_served[m]);
            if (gap > 0) begin
              m_phase[m] = 2;
              m_left[m]  = gap;
            end else begin
              m_phase[m] = 0;
            end
          end
        end
        default: begin
          m_left[m]--;
          if (m_left[m] == 0) m_phase[m] = 0;
        end
      endcase
      m_pend[m] = m_pend[m] | r;
    end
  endtask

  task automatic check_inst(input int m, input logic [3:0] led, input logic busy,
                            input logic [3:0] pend, input logic [3:0] ack,
                            input logic [1:0] gid);
    string      p;
    logic [3:0] exp_led;
    p       = (m == 0) ? "a" : "b";
    exp_led = (m_phase[m] == 1) ? 4'(1 << m_served[m]) : 4'b0000;
    check({p, ".led_on"},  32'(led),  32'(exp_led));
    check({p, ".busy"},    32'(busy), 32'(m_phase[m] != 0));
    check({p, ".pending"}, 32'(pend), 32'(m_pend[m]));
    check({p, ".ack"},     32'(ack),  32'(m_ack[m]));
    if (m_phase[m] != 0) check({p, ".grant_id"}, 32'(gid), 32'(m_served[m]));
  endtask

  task automatic compare_all();
    check_inst(0, bus_a.led_on, bus_a.busy, bus_a.pending, bus_a.ack, bus_a.grant_id);
    check_inst(1, bus_b.led_on, bus_b.busy, bus_b.pending, bus_b.ack, bus_b.grant_id);
  endtask

  // Grant-order scoreboard for instance a: one entry popped per busy rise.
  logic [1:0] exp_q[$];
  bit         sb_on       = 1'b0;
  logic       prev_busy_a = 1'b0;

  task automatic drive(input logic [3:0] r, input logic c);
    bus_a.req   = r;
    bus_b.req   = r;
    bus_a.clear = c;
    bus_b.clear = c;
  endtask

  task automatic cycle_now(input logic [3:0] r, input logic c);
    drive(r, c);
    @(posedge clk);
    model_step(0, r, c);
    model_step(1, r, c);
    #1;
    compare_all();
    if (sb_on && bus_a.busy && !prev_busy_a) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL grant_order: unexpected grant %0d, expected none", bus_a.grant_id);
      end else begin
        check("grant_order", 32'(bus_a.grant_id), 32'(exp_q.pop_front()));
      end
    end
    prev_busy_a = bus_a.busy;
  endtask

  task automatic cycle(input logic [3:0] r, input logic c);
    @(negedge clk);
    cycle_now(r, c);
  endtask

  task automatic sb_done(input string name);
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    sb_on = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(4'b0000, 1'b0);
    model_reset();
    prev_busy_a = 1'b0;
    #1;
    compare_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic [3:0] req;
    logic       clear;
    logic [3:0] led;
    logic       busy;
    logic [3:0] pend;
    logic [3:0] ack;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] r, input logic c, input logic [3:0] led,
                              input logic busy, input logic [3:0] pend, input logic [3:0] ack);
    vec_t v;
    v.req   = r;
    v.clear = c;
    v.led   = led;
    v.busy  = busy;
    v.pend  = pend;
    v.ack   = ack;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r;
    logic       c;

    drive(4'b0000, 1'b0);
    model_reset();

    // Single request: pend, 8 lit cycles, ack, 3 dark cycles, idle.
    vecs.push_back(mk(4'b0100, 1'b0, 4'b0000, 1'b0, 4'b0100, 4'b0000));
    for (int i = 0; i < FLASH; i++)
      vecs.push_back(mk(4'b0000, 1'b0, 4'b0100, 1'b1, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0100));
    for (int i = 1; i < GAP_A; i++)
      vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000));

    do_reset();
    foreach (vecs[i]) begin
      cycle(vecs[i].req, vecs[i].clear);
      check($sformatf("vec%0d.led_on", i),  32'(bus_a.led_on),  32'(vecs[i].led));
      check($sformatf("vec%0d.busy", i),    32'(bus_a.busy),    32'(vecs[i].busy));
      check($sformatf("vec%0d.pending", i), 32'(bus_a.pending), 32'(vecs[i].pend));
      check($sformatf("vec%0d.ack", i),     32'(bus_a.ack),     32'(vecs[i].ack));
    end

    // All four requesting at once after reset: served 0,1,2,3.
    do_reset();
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3};
    sb_on = 1'b1;
    cycle(4'b1111, 1'b0);
    repeat (52) cycle(4'b0000, 1'b0);
    sb_done("rr_all_served");

    // Requester 0 re-requests during its own flash while 1 waits.
    do_reset();
    exp_q = '{2'd0, 2'd1, 2'd0};
    sb_on = 1'b1;
    cycle(4'b0011, 1'b0);
    cycle(4'b0000, 1'b0);
    cycle(4'b0001, 1'b0);
    repeat (40) cycle(4'b0000, 1'b0);
    sb_done("rerequest_order");

    // Clear at flash count 4 with requester 3 pending.
    do_reset();
    cycle(4'b0001, 1'b0);
    cycle(4'b1000, 1'b0);
    repeat (4) cycle(4'b0000, 1'b0);
    check("pre_clear.pending", 32'(bus_a.pending), 32'h8);
    cycle(4'b0000, 1'b1);
    check("clear.led_on",  32'(bus_a.led_on),  32'h0);
    check("clear.busy",    32'(bus_a.busy),    32'h0);
    check("clear.pending", 32'(bus_a.pending), 32'h0);
    check("clear.ack",     32'(bus_a.ack),     32'h0);
    for (int i = 0; i < 4; i++) begin
      cycle(4'b0000, 1'b0);
      check("post_clear.ack", 32'(bus_a.ack), 32'h0);
    end
    cycle(4'b0100, 1'b0);
    repeat (14) cycle(4'b0000, 1'b0);

    // Asynchronous reset in the middle of the dark gap.
    do_reset();
    cycle(4'b0100, 1'b0);
    repeat (10) cycle(4'b0000, 1'b0);
    check("gap.busy",   32'(bus_a.busy),   32'h1);
    check("gap.led_on", 32'(bus_a.led_on), 32'h0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    model_reset();
    prev_busy_a = 1'b0;
    #1;
    check("async.led_on",   32'(bus_a.led_on),   32'h0);
    check("async.busy",     32'(bus_a.busy),     32'h0);
    check("async.pending",  32'(bus_a.pending),  32'h0);
    check("async.ack",      32'(bus_a.ack),      32'h0);
    check("async.grant_id", 32'(bus_a.grant_id), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    exp_q = '{2'd0, 2'd1};
    sb_on = 1'b1;
    cycle_now(4'b0011, 1'b0);
    repeat (26) cycle(4'b0000, 1'b0);
    sb_done("after_reset_order");

    // Zero-gap instance: flash 0, ack with one idle cycle, then flash 1.
    do_reset();
    cycle(4'b0011, 1'b0);
    for (int i = 1; i <= 11; i++) begin
      cycle(4'b0000, 1'b0);
      if (i <= FLASH) begin
        check($sformatf("zgap%0d.led_on", i), 32'(bus_b.led_on), 32'h1);
      end else if (i == FLASH + 1) begin
        check("zgap.idle_led_on", 32'(bus_b.led_on), 32'h0);
        check("zgap.idle_busy",   32'(bus_b.busy),   32'h0);
        check("zgap.ack",         32'(bus_b.ack),    32'h1);
      end else begin
        check($sformatf("zgap%0d.led_on", i), 32'(bus_b.led_on), 32'h2);
      end
    end

    // Random traffic with occasional aborts against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 7) == 0);
      c = ($urandom_range(0, 149) == 0);
      cycle(r, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_flash_arbiter.md
LED_FLASH_ARBITER -- requirements
Module: led_flash_arbiter

Interface
REQ-001 Parameter SYS_FREQ, default 100000000: system clock frequency in Hz; informational, no effect on timing.
REQ-002 Parameter FLASH_CYCLES, default 50000000: clock cycles for which one granted flash lights the LEDs; legal range 2..2^32-1.
REQ-003 Parameter GAP_CYCLES, default 10000000: dark cycles after each flash; legal range 0..2^32-1.
REQ-004 Port clk, input, 1: single system clock; all state SHALL change on its rising edge only.
REQ-005 Port reset, input, 1: asynchronous, active-low reset; low SHALL reset all state immediately, independent of clk.
REQ-006 Port req, input, 4: per-requester flash request; bit i high in any cycle SHALL register one request from requester i (0 over-temp, 1 under-temp, 2 sensor fault, 3 info).
REQ-007 Port clear, input, 1: synchronous abort; drops all pending requests and any flash in progress.
REQ-008 Port led_on, output, 4: shared LED bank drive.
REQ-009 Port grant_id, output, 2: index of the requester currently being served; valid only while busy is high.
REQ-010 Port busy, output, 1: high in FLASH and GAP states.
REQ-011 Port pending, output, 4: registered sticky request flags.
REQ-012 Port ack, output, 4: one-cycle pulse on bit i when requester i's flash completes normally.

Function
REQ-013 States: IDLE, FLASH, GAP; all outputs SHALL be registered or decoded from registered state only (Moore), with no combinational path from req or clear to any output.
REQ-014 At each rising edge, pending[i] SHALL set when req[i]=1 and clear only on grant of i or on clear; if set and grant-clear coincide for the same bit, set SHALL win.
REQ-015 In IDLE with pending nonzero, the arbiter SHALL select round-robin, searching from (last_grant+1) mod 4 upward with wrap; at that edge it SHALL clear pending[sel], load grant_id=sel, update last_grant=sel, load count=0, and enter FLASH.
REQ-016 Latency: a req pulse at edge N with the arbiter in IDLE and no other request pending SHALL produce busy=1 and led_on lit from edge N+1.
REQ-017 In FLASH: led_on = 4'b0001 << grant_id; count increments by 1 per cycle; FLASH SHALL last exactly FLASH_CYCLES cycles.
REQ-018 On the edge at which count = FLASH_CYCLES-1 in FLASH: the arbiter SHALL assert ack[grant_id] for the following cycle only, reset count to 0, and enter GAP, or enter IDLE directly if GAP_CYCLES = 0.
REQ-019 In GAP: led_on = 0, busy = 1; GAP SHALL last exactly GAP_CYCLES cycles, then the arbiter SHALL enter IDLE.
REQ-020 In IDLE: led_on = 0 and busy = 0; IDLE SHALL last at least one cycle between grants.
REQ-021 A request from the requester being served, arriving during FLASH or GAP, SHALL re-set its pending bit and be served again in round-robin order.
REQ-022 Counter SHALL be 32 bits unsigned and SHALL never wrap within legal parameter ranges.
REQ-023 clear=1 at an edge SHALL force pending=0, count=0, and state IDLE with no ack; clear SHALL take priority over req and all state transitions in the same cycle; last_grant SHALL be retained.

Reset
REQ-024 With reset low: state=IDLE, count=0, pending=0, led_on=0, ack=0, busy=0, grant_id=0, last_grant=3, so requester 0 wins the first tie.
REQ-025 Reset asserted mid-FLASH or mid-GAP SHALL abort immediately with no ack; after release, requests SHALL be accepted from the first rising edge.

Verification (FLASH_CYCLES=8, GAP_CYCLES=3)
REQ-026 Single request: req=4'b0100 for 1 cycle -> led_on=4'b0100 for exactly 8 cycles starting next cycle; ack=4'b0100 for 1 cycle; led_on=0 with busy=1 for 3 cycles; then busy=0.
REQ-027 Round-robin: req=4'b1111 for 1 cycle after reset -> grants in order 0,1,2,3, each 8 lit cycles with 3-cycle gap and 1 IDLE cycle between; pending decrements one bit per grant.
REQ-028 Re-request: req=4'b0001 during requester 0's FLASH, with 4'b0010 also pending -> serve 1, then 0 again.
REQ-029 Clear mid-flash: clear=1 at FLASH count=4 with pending=4'b1000 -> next cycle led_on=0, busy=0, pending=0, no ack.
REQ-030 Async reset mid-GAP: reset low between clock edges -> all outputs zero before the next edge; after release, req=4'b0011 -> requester 0 granted first.
REQ-031 Zero gap: GAP_CYCLES=0, req=4'b0011 -> flash 0 for 8 cycles, ack, 1 IDLE cycle, then flash 1.
